// File: rtl/sdram_access_sched_if.sv
// ============================================================================
// Module      : sdram_access_sched_if
// Description : Request/grant/refresh bundle between the SDRAM data paths and
//               the access scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_access_sched_if #(
  parameter int PEND_WIDTH = 4
);
  logic                  i_init_done;
  logic                  i_wr_req;
  logic                  i_rd_req;
  logic                  i_done;
  logic                  o_wr_gnt;
  logic                  o_rd_gnt;
  logic                  o_ref_cmd;
  logic                  o_busy;
  logic [PEND_WIDTH-1:0] o_ref_pend;
  logic                  o_ref_ovf;

  modport master (
    output i_init_done, i_wr_req, i_rd_req, i_done,
    input  o_wr_gnt, o_rd_gnt, o_ref_cmd, o_busy, o_ref_pend, o_ref_ovf
  );

  modport slave (
    input  i_init_done, i_wr_req, i_rd_req, i_done,
    output o_wr_gnt, o_rd_gnt, o_ref_cmd, o_busy, o_ref_pend, o_ref_ovf
  );
endinterface

`default_nettype wire

// File: rtl/sdram_access_sched.sv
// ============================================================================
// Module      : sdram_access_sched
// Description : Arbitrates the SDRAM command bus between write bursts, read
//               bursts and auto-refresh, with an urgent-refresh override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_access_sched #(
  parameter int REF_INTERVAL  = 780,
  parameter int PEND_WIDTH    = 4,
  parameter int URGENT_THRESH = 4,
  parameter int T_RC          = 7
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  sdram_access_sched_if.slave  sched_bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GNT_WR   = 3'd1;
  localparam logic [2:0] S_GNT_RD   = 3'd2;
  localparam logic [2:0] S_REFRESH  = 3'd3;
  localparam logic [2:0] S_REF_WAIT = 3'd4;

  localparam int                    c_WCW       = $clog2(T_RC);
  localparam logic [15:0]           c_TIMER_MAX = 16'(REF_INTERVAL - 1);
  localparam logic [PEND_WIDTH-1:0] c_PEND_MAX  = {PEND_WIDTH{1'b1}};
  localparam logic [PEND_WIDTH-1:0] c_URGENT    = PEND_WIDTH'(URGENT_THRESH);
  localparam logic [c_WCW-1:0]      c_WAIT_LAST = c_WCW'(T_RC - 2);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [15:0]           r_timer;
  logic [PEND_WIDTH-1:0] r_pend;
  logic                  r_ovf;
  logic                  r_last_wr;
  logic [c_WCW-1:0]      r_wait;
  logic                  w_tick;
  logic                  w_ref;
  logic                  w_sat;

  assign w_tick = sched_bus.i_init_done && (r_timer == c_TIMER_MAX);
  assign w_ref  = (r_state == S_REFRESH);
  assign w_sat  = (r_pend == c_PEND_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (!sched_bus.i_init_done || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // A tick and a refresh in the same cycle cancel; a tick at saturation is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else if (!sched_bus.i_init_done) begin
      r_pend <= '0;
    end else begin
      if (w_tick && w_sat)
        r_ovf <= 1'b1;
      if (w_tick && !w_ref && !w_sat)
        r_pend <= r_pend + PEND_WIDTH'(1);
      else if (!w_tick && w_ref && (r_pend != '0))
        r_pend <= r_pend - PEND_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!sched_bus.i_init_done) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend >= c_URGENT)
            w_state_nxt = S_REFRESH;
          else if (sched_bus.i_wr_req && sched_bus.i_rd_req)
            w_state_nxt = r_last_wr ? S_GNT_RD : S_GNT_WR;
          else if (sched_bus.i_wr_req)
            w_state_nxt = S_GNT_WR;
          else if (sched_bus.i_rd_req)
            w_state_nxt = S_GNT_RD;
          else if (r_pend != '0)
            w_state_nxt = S_REFRESH;
        end
        S_GNT_WR, S_GNT_RD: begin
          if (sched_bus.i_done)
            w_state_nxt = S_IDLE;
        end
        S_REFRESH:  w_state_nxt = S_REF_WAIT;
        S_REF_WAIT: begin
          if (r_wait == c_WAIT_LAST)
            w_state_nxt = S_IDLE;
        end
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // An aborted burst does not count as served.
      if (sched_bus.i_init_done && sched_bus.i_done) begin
        if (r_state == S_GNT_WR)
          r_last_wr <= 1'b1;
        else if (r_state == S_GNT_RD)
          r_last_wr <= 1'b0;
      end
      if (r_state == S_REFRESH)
        r_wait <= '0;
      else if (r_state == S_REF_WAIT)
        r_wait <= r_wait + c_WCW'(1);
    end
  end

  assign sched_bus.o_wr_gnt   = (r_state == S_GNT_WR);
  assign sched_bus.o_rd_gnt   = (r_state == S_GNT_RD);
  assign sched_bus.o_ref_cmd  = w_ref;
  assign sched_bus.o_busy     = (r_state != S_IDLE);
  assign sched_bus.o_ref_pend = r_pend;
  assign sched_bus.o_ref_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sdram_access_sched.sv
// ============================================================================
// Module      : tb_sdram_access_sched
// Description : Self-checking bench for sdram_access_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_access_sched;
  localparam int REF_INTERVAL  = 20;
  localparam int PEND_WIDTH    = 4;
  localparam int URGENT_THRESH = 4;
  localparam int T_RC          = 7;
  localparam int PEND_MAX      = (1 << PEND_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n;

  sdram_access_sched_if #(.PEND_WIDTH(PEND_WIDTH)) bus ();

  sdram_access_sched #(
    .REF_INTERVAL (REF_INTERVAL),
    .PEND_WIDTH   (PEND_WIDTH),
    .URGENT_THRESH(URGENT_THRESH),
    .T_RC         (T_RC)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .sched_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner of the bus (0 none, 1 WR, 2 RD) and a countdown
  // covering the refresh strobe plus its recovery window.
  int m_timer, m_pend, m_owner, m_ref_left, m_last;
  bit m_ovf;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_out();
    return {bus.o_wr_gnt, bus.o_rd_gnt, bus.o_ref_cmd, bus.o_busy,
            bus.o_ref_pend, bus.o_ref_ovf};
  endfunction

  function automatic logic [8:0] model_out();
    logic [3:0] p;
    p = 4'(m_pend);
    return {m_owner == 1, m_owner == 2, m_ref_left == T_RC,
            (m_owner != 0) || (m_ref_left != 0), p, m_ovf};
  endfunction

  task automatic model_reset();
    m_timer = 0; m_pend = 0; m_owner = 0; m_ref_left = 0; m_last = 2; m_ovf = 0;
  endtask

  task automatic model_step(input bit init, input bit wr, input bit rd, input bit done);
    bit tick, refnow;
    int p;
    if (!init) begin
      m_timer = 0; m_pend = 0; m_owner = 0; m_ref_left = 0;
      return;
    end
    tick   = (m_timer == REF_INTERVAL - 1);
    refnow = (m_ref_left == T_RC);
    p = m_pend;
    if (tick && p == PEND_MAX) m_ovf = 1;
    if (tick && !refnow) p = (p < PEND_MAX) ? p + 1 : p;
    else if (refnow && !tick) p = p - 1;
    if (m_owner != 0) begin
      if (done) begin m_last = m_owner; m_owner = 0; end
    end else if (m_ref_left != 0) m_ref_left--;
    else if (m_pend >= URGENT_THRESH) m_ref_left = T_RC;
    else if (wr && rd) m_owner = (m_last == 1) ? 2 : 1;
    else if (wr) m_owner = 1;
    else if (rd) m_owner = 2;
    else if (m_pend > 0) m_ref_left = T_RC;
    m_pend  = p;
    m_timer = tick ? 0 : m_timer + 1;
  endtask

  task automatic cycle(string tag);
    bit init, wr, rd, done;
    init = bus.i_init_done; wr = bus.i_wr_req; rd = bus.i_rd_req; done = bus.i_done;
    @(posedge clk);
    model_step(init, wr, rd, done);
    #1;
    check(tag, dut_out(), model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_init_done = 0; bus.i_wr_req = 0; bus.i_rd_req = 0; bus.i_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_out(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset");
  endtask

  typedef struct {
    bit init, wr, rd, done;
    bit e_wr, e_rd, e_ref, e_busy;
    int e_pend;
  } vec_t;

  vec_t vt[16];

  initial begin
    int refs[$];
    int order[$];
    int held, gap, first_pend, nref;
    bit seen;

    vt[0]  = '{1,1,1,0, 1,0,0,1, 0};
    vt[1]  = '{1,1,1,0, 1,0,0,1, 0};
    vt[2]  = '{1,1,1,1, 0,0,0,0, 0};
    vt[3]  = '{1,1,1,0, 0,1,0,1, 0};
    vt[4]  = '{1,1,1,1, 0,0,0,0, 0};
    vt[5]  = '{1,0,1,0, 0,1,0,1, 0};
    vt[6]  = '{1,0,1,1, 0,0,0,0, 0};
    vt[7]  = '{1,1,0,0, 1,0,0,1, 0};
    vt[8]  = '{1,1,0,0, 1,0,0,1, 0};
    vt[9]  = '{0,1,0,0, 0,0,0,0, 0};
    vt[10] = '{0,1,0,0, 0,0,0,0, 0};
    vt[11] = '{1,1,0,0, 1,0,0,1, 0};
    vt[12] = '{1,0,0,1, 0,0,0,0, 0};
    vt[13] = '{1,0,0,1, 0,0,0,0, 0};
    vt[14] = '{1,1,1,0, 0,1,0,1, 0};
    vt[15] = '{1,1,1,1, 0,0,0,0, 0};

    // Table-driven arbitration and abort vectors.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.i_init_done = vt[i].init; bus.i_wr_req = vt[i].wr;
      bus.i_rd_req = vt[i].rd; bus.i_done = vt[i].done;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {bus.o_wr_gnt, bus.o_rd_gnt, bus.o_ref_cmd, bus.o_busy, bus.o_ref_pend, bus.o_ref_ovf},
            {vt[i].e_wr, vt[i].e_rd, vt[i].e_ref, vt[i].e_busy, 4'(vt[i].e_pend), 1'b0});
    end

    // Idle refresh cadence.
    do_reset();
    bus.i_init_done = 1;
    first_pend = 0;
    refs.delete();
    for (int k = 1; k <= 60; k++) begin
      cycle("t1_model");
      if (first_pend == 0 && bus.o_ref_pend == 4'd1) first_pend = k;
      if (bus.o_ref_cmd) refs.push_back(k);
    end
    check("t1_first_tick", first_pend, REF_INTERVAL);
    check("t1_nrefs", refs.size(), 2);
    if (refs.size() == 2) begin
      check("t1_ref_delay", refs[0], REF_INTERVAL + 1);
      check("t1_spacing_ok", (refs[1] - refs[0]) >= T_RC, 1);
    end

    // Round-robin with both requests held.
    do_reset();
    bus.i_init_done = 1; bus.i_wr_req = 1; bus.i_rd_req = 1;
    held = 0;
    order.delete();
    for (int k = 0; k < 40; k++) begin
      cycle("t2_model");
      bus.i_done = 0;
      if (bus.o_wr_gnt || bus.o_rd_gnt) begin
        if (held == 0) order.push_back(bus.o_wr_gnt ? 1 : 2);
        held++;
        if (held == 8) bus.i_done = 1;
      end else held = 0;
    end
    bus.i_done = 0;
    check("t2_ngrants", order.size() >= 4, 1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("t2_order%0d", i), order[i], (i % 2 == 0) ? 1 : 2);

    // Back-to-back reads with one idle cycle between grants.
    do_reset();
    bus.i_init_done = 1; bus.i_rd_req = 1;
    held = 0; gap = 0; seen = 0; nref = 0;
    for (int k = 0; k < 30; k++) begin
      cycle("t3_model");
      bus.i_done = 0;
      if (bus.o_rd_gnt) begin
        if (seen && held == 0) begin
          check($sformatf("t3_gap%0d", nref), gap, 1);
          nref++;
        end
        seen = 1; held++; gap = 0;
        if (held == 3) bus.i_done = 1;
      end else begin
        held = 0;
        if (seen) gap++;
      end
    end
    bus.i_done = 0;
    check("t3_ngaps", nref >= 3, 1);

    // Long write burst builds an urgent backlog.
    do_reset();
    bus.i_init_done = 1; bus.i_wr_req = 1;
    cycle("t4_grant");
    bus.i_rd_req = 1;
    repeat (99) cycle("t4_hold");
    check("t4_pend_at_done", bus.o_ref_pend, 5);
    bus.i_done = 1;
    cycle("t4_done");
    bus.i_done = 0; bus.i_wr_req = 0;
    cycle("t4_next");
    check("t4_refresh_first", bus.o_ref_cmd, 1);
    nref = 1;
    for (int k = 0; k < 40 && !bus.o_rd_gnt; k++) begin
      cycle("t4_drain");
      if (bus.o_ref_cmd) nref++;
    end
    check("t4_rd_granted", bus.o_rd_gnt, 1);
    check("t4_nrefs", nref, 2);
    check("t4_pend_at_rd", bus.o_ref_pend, 3);
    bus.i_rd_req = 0;

    // Saturation and overflow during a stalled burst.
    do_reset();
    bus.i_init_done = 1; bus.i_wr_req = 1;
    cycle("t5_grant");
    bus.i_wr_req = 0;
    repeat (15 * REF_INTERVAL - 1) cycle("t5_hold");
    check("t5_sat_no_ovf", {bus.o_ref_pend, bus.o_ref_ovf}, {4'd15, 1'b0});
    repeat (REF_INTERVAL) cycle("t5_hold2");
    check("t5_ovf", {bus.o_ref_pend, bus.o_ref_ovf}, {4'd15, 1'b1});
    bus.i_done = 1;
    cycle("t5_done");
    bus.i_done = 0;
    for (int k = 0; k < 1000 && bus.o_ref_pend != 0; k++) cycle("t5_drain");
    check("t5_drained", bus.o_ref_pend, 0);
    check("t5_ovf_sticky", bus.o_ref_ovf, 1);

    // Init loss mid-grant and mid-REF_WAIT.
    do_reset();
    bus.i_init_done = 1; bus.i_wr_req = 1;
    repeat (25) cycle("t6_hold");
    bus.i_init_done = 0;
    cycle("t6_abort_gnt");
    check("t6_abort_gnt_out", dut_out(), 9'd0);
    bus.i_wr_req = 0; bus.i_init_done = 1;
    first_pend = 0;
    for (int k = 1; k <= 23; k++) begin
      cycle("t6_restart");
      if (first_pend == 0 && bus.o_ref_pend == 4'd1) first_pend = k;
    end
    check("t6_timer_restart", first_pend, REF_INTERVAL);
    check("t6_in_wait", {bus.o_busy, bus.o_ref_cmd}, 2'b10);
    bus.i_init_done = 0;
    cycle("t6_abort_wait");
    check("t6_abort_wait_out", dut_out(), 9'd0);

    // Asynchronous reset mid-burst.
    do_reset();
    bus.i_init_done = 1; bus.i_rd_req = 1;
    repeat (2) cycle("t7_grant");
    #2 rst_n = 1'b0;
    #1 check("t7_async_reset", dut_out(), 9'd0);
    do_reset();

    // Randomised traffic against the model.
    bus.i_init_done = 1;
    for (int k = 0; k < 4000; k++) begin
      if (bus.i_init_done) begin
        if ($urandom_range(399) == 0) bus.i_init_done = 0;
      end else if ($urandom_range(3) == 0) bus.i_init_done = 1;
      if (bus.o_wr_gnt) bus.i_wr_req = 0;
      else if (!bus.i_wr_req && $urandom_range(7) == 0) bus.i_wr_req = 1;
      if (bus.o_rd_gnt) bus.i_rd_req = 0;
      else if (!bus.i_rd_req && $urandom_range(7) == 0) bus.i_rd_req = 1;
      if (bus.o_wr_gnt || bus.o_rd_gnt)
        bus.i_done = ($urandom_range(((k / 1000) % 2 == 1) ? 149 : 9) == 0);
      else
        bus.i_done = ($urandom_range(29) == 0);
      cycle("rand_model");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
